inst_fetch_arb: RTL and testbench

INST_FETCH_ARB -- requirements
Module: inst_fetch_arb

---
 rtl/inst_fetch_arb.sv | 107 ++++++++++
 tb/tb_inst_fetch_arb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_arb.sv
// Two-requester instruction ROM arbiter: fetch has priority, debug/loader is granted after FETCH_BURST_MAX contended fetches.
// Optional macro INST_FETCH_ARB_ALIGN_CHK_EN rejects misaligned accesses with err instead of reading the ROM.
module inst_fetch_arb #(
    parameter int FETCH_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        rom_ce,
    output logic [31:0] rom_pc,
    input  logic [31:0] rom_inst,
    output logic        err,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(FETCH_BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FETCH_BURST_MAX);

    typedef enum logic [1:0] {
        LAST_NONE = 2'd0,
        LAST_F    = 2'd1,
        LAST_D    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          f_rvalid_q, d_rvalid_q;
    logic          mis_q;
    logic          any_gnt;
    logic [31:0]   gnt_addr;

    // Handshake: a requester holds req/addr until it sees gnt in the same
    // cycle; the owner's rvalid follows exactly one cycle after its gnt and
    // is never back-pressured. Grants are gated by reset_n so nothing is
    // accepted while reset is held.
    always_comb begin
        f_gnt   = 1'b0;
        d_gnt   = 1'b0;
        state_d = LAST_NONE;
        cnt_d   = cnt_q;
        if (reset_n) begin
            if (f_req && d_req) begin
                if (cnt_q == CNT_MAX) d_gnt = 1'b1;
                else                  f_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
        if (f_gnt)      state_d = LAST_F;
        else if (d_gnt) state_d = LAST_D;
        // Starvation counter tracks fetch grants taken while debug waits.
        if (d_gnt || !d_req)               cnt_d = '0;
        else if (f_gnt && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    assign any_gnt  = f_gnt | d_gnt;
    assign gnt_addr = f_gnt ? f_addr : (d_gnt ? d_addr : 32'd0);
    assign rom_pc   = gnt_addr;

`ifdef INST_FETCH_ARB_ALIGN_CHK_EN
    logic mis_now;
    assign mis_now = any_gnt && (gnt_addr[1:0] != 2'b00);
    assign rom_ce  = any_gnt && !mis_now;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mis_q <= 1'b0;
        else          mis_q <= mis_now;
    end
`else
    assign rom_ce = any_gnt;
    assign mis_q  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LAST_NONE;
            cnt_q      <= '0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            f_rvalid_q <= f_gnt;
            d_rvalid_q <= d_gnt;
        end
    end

    // ROM data is already registered one cycle behind rom_ce; steer it to the owner.
    assign f_rvalid  = f_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign f_rdata   = (f_rvalid_q && !mis_q) ? rom_inst : 32'd0;
    assign d_rdata   = (d_rvalid_q && !mis_q) ? rom_inst : 32'd0;
    assign err       = mis_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_inst_fetch_arb.sv
// Directed self-checking bench for inst_fetch_arb with a registered ROM model (word n = 0xC0DE0000 | n).
module tb_inst_fetch_arb;

    logic        clk;
    logic        reset_n;
    logic        f_req, d_req;
    logic [31:0] f_addr, d_addr;
    logic        f_gnt, d_gnt, f_rvalid, d_rvalid, rom_ce, err;
    logic [31:0] f_rdata, d_rdata, rom_pc, rom_inst;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    inst_fetch_arb #(.FETCH_BURST_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .rom_ce(rom_ce), .rom_pc(rom_pc), .rom_inst(rom_inst), .err(err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: registered, zero when not enabled
    always @(posedge clk) begin
        rom_inst <= rom_ce ? (32'hC0DE0000 | {16'h0, rom_pc[17:2]}) : 32'd0;
    end

    task automatic test_reset();
        reset_n = 1'b0; f_req = 1'b1; d_req = 1'b1; f_addr = 32'h4; d_addr = 32'h8;
        @(negedge clk); #1;
        checks++; if (f_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got f=%b d=%b exp 0 0", f_gnt, d_gnt); end
        checks++; if (rom_ce !== 1'b0 || rom_pc !== 32'd0) begin errors++; $display("FAIL reset_rom got ce=%b pc=%h exp 0 0", rom_ce, rom_pc); end
        checks++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_valid got f=%b d=%b err=%b exp 0", f_rvalid, d_rvalid, err); end
        checks++; if (f_rdata !== 32'd0 || d_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h %h exp 0", f_rdata, d_rdata); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        f_req = 1'b0; d_req = 1'b0;
        @(negedge clk); reset_n = 1'b1; #1;
        checks++; if (f_gnt !== 1'b0 || d_gnt !== 1'b0 || rom_ce !== 1'b0) begin errors++; $display("FAIL post_reset_idle got f=%b d=%b ce=%b exp 0", f_gnt, d_gnt, rom_ce); end
        @(negedge clk); #1;
        checks++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid got f=%b d=%b exp 0", f_rvalid, d_rvalid); end
    endtask

    task automatic test_fetch_seq();
        logic [31:0] exp_w [3];
        exp_w = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); f_req = 1'b1; f_addr = 32'(i * 4); #1;
            checks++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt[%0d] got f=%b d=%b exp 1 0", i, f_gnt, d_gnt); end
            checks++; if (rom_ce !== 1'b1 || rom_pc !== 32'(i * 4)) begin errors++; $display("FAIL fetch_rom[%0d] got ce=%b pc=%h exp 1 %h", i, rom_ce, rom_pc, i * 4); end
            if (i > 0) begin
                checks++; if (f_rvalid !== 1'b1 || f_rdata !== exp_w[i-1]) begin errors++; $display("FAIL fetch_rdata[%0d] got v=%b %h exp 1 %h", i - 1, f_rvalid, f_rdata, exp_w[i-1]); end
            end
            checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_d_rvalid[%0d] got %b exp 0", i, d_rvalid); end
        end
        // requester drops req after its last grant; response is still driven
        @(negedge clk); f_req = 1'b0; #1;
        checks++; if (f_gnt !== 1'b0) begin errors++; $display("FAIL fetch_idle_gnt got %b exp 0", f_gnt); end
        checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hC0DE0002) begin errors++; $display("FAIL fetch_rdata[2] got v=%b %h exp 1 c0de0002", f_rvalid, f_rdata); end
        checks++; if (d_rvalid !== 1'b0 || d_rdata !== 32'd0) begin errors++; $display("FAIL fetch_d_idle got v=%b %h exp 0 0", d_rvalid, d_rdata); end
        @(negedge clk); #1;
        checks++; if (f_rvalid !== 1'b0 || f_rdata !== 32'd0) begin errors++; $display("FAIL fetch_drain got v=%b %h exp 0 0", f_rvalid, f_rdata); end
    endtask

    task automatic test_debug_alone();
        @(negedge clk); d_req = 1'b1; d_addr = 32'h10; #1;
        checks++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0 || rom_pc !== 32'h10) begin errors++; $display("FAIL dbg_gnt got d=%b f=%b pc=%h exp 1 0 10", d_gnt, f_gnt, rom_pc); end
        @(negedge clk); d_req = 1'b0; #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hC0DE0004) begin errors++; $display("FAIL dbg_rdata got v=%b %h exp 1 c0de0004", d_rvalid, d_rdata); end
        checks++; if (f_rvalid !== 1'b0 || f_rdata !== 32'd0) begin errors++; $display("FAIL dbg_f_quiet got v=%b %h exp 0 0", f_rvalid, f_rdata); end
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL dbg_state got %0d exp 2", dbg_state); end
    endtask

    task automatic test_starvation();
        logic exp_d, prev_d;
        prev_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_d = (i == 4) || (i == 9);
            @(negedge clk); f_req = 1'b1; d_req = 1'b1; f_addr = 32'h20; d_addr = 32'h40; #1;
            checks++; if (d_gnt !== exp_d || f_gnt !== !exp_d) begin errors++; $display("FAIL starve_gnt[%0d] got f=%b d=%b exp d=%b", i, f_gnt, d_gnt, exp_d); end
            checks++; if (rom_pc !== (exp_d ? 32'h40 : 32'h20)) begin errors++; $display("FAIL starve_pc[%0d] got %h", i, rom_pc); end
            if (i > 0) begin
                checks++;
                if (prev_d ? (d_rvalid !== 1'b1 || d_rdata !== 32'hC0DE0010 || f_rvalid !== 1'b0 || f_rdata !== 32'd0)
                           : (f_rvalid !== 1'b1 || f_rdata !== 32'hC0DE0008 || d_rvalid !== 1'b0 || d_rdata !== 32'd0)) begin
                    errors++; $display("FAIL starve_resp[%0d] got f=%b/%h d=%b/%h exp owner d=%b", i - 1, f_rvalid, f_rdata, d_rvalid, d_rdata, prev_d);
                end
                checks++; if (dbg_state !== (prev_d ? 2'd2 : 2'd1)) begin errors++; $display("FAIL starve_state[%0d] got %0d", i - 1, dbg_state); end
            end
            prev_d = exp_d;
        end
        @(negedge clk); f_req = 1'b0; d_req = 1'b0; #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hC0DE0010 || f_rvalid !== 1'b0) begin errors++; $display("FAIL starve_last got d=%b/%h f=%b exp 1/c0de0010 0", d_rvalid, d_rdata, f_rvalid); end
        @(negedge clk); #1;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL starve_none got %0d exp 0", dbg_state); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); f_req = 1'b1; f_addr = 32'hC; #1;
        checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL b2b_g0 got %b exp 1", f_gnt); end
        @(negedge clk); f_req = 1'b0; d_req = 1'b1; d_addr = 32'h14; #1;
        checks++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0) begin errors++; $display("FAIL b2b_g1 got d=%b f=%b exp 1 0", d_gnt, f_gnt); end
        checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hC0DE0003 || d_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_r0 got f=%b/%h d=%b", f_rvalid, f_rdata, d_rvalid); end
        @(negedge clk); d_req = 1'b0; f_req = 1'b1; f_addr = 32'h18; #1;
        checks++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL b2b_g2 got f=%b d=%b exp 1 0", f_gnt, d_gnt); end
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hC0DE0005 || f_rvalid !== 1'b0 || f_rdata !== 32'd0) begin errors++; $display("FAIL b2b_r1 got d=%b/%h f=%b/%h", d_rvalid, d_rdata, f_rvalid, f_rdata); end
        @(negedge clk); f_req = 1'b0; #1;
        checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hC0DE0006 || d_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_r2 got f=%b/%h d=%b", f_rvalid, f_rdata, d_rvalid); end
    endtask

    task automatic test_misaligned();
        logic        exp_ce, exp_err;
        logic [31:0] exp_data;
`ifdef INST_FETCH_ARB_ALIGN_CHK_EN
        exp_ce = 1'b0; exp_err = 1'b1; exp_data = 32'd0;
`else
        exp_ce = 1'b1; exp_err = 1'b0; exp_data = 32'hC0DE0001;
`endif
        @(negedge clk); f_req = 1'b1; f_addr = 32'h6; #1;
        checks++; if (f_gnt !== 1'b1 || rom_ce !== exp_ce) begin errors++; $display("FAIL mis_ce got gnt=%b ce=%b exp 1 %b", f_gnt, rom_ce, exp_ce); end
        @(negedge clk); f_req = 1'b0; #1;
        checks++; if (f_rvalid !== 1'b1 || f_rdata !== exp_data) begin errors++; $display("FAIL mis_rdata got v=%b %h exp 1 %h", f_rvalid, f_rdata, exp_data); end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL mis_err got %b exp %b", err, exp_err); end
        @(negedge clk); #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_err_clear got %b exp 0", err); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); f_req = 1'b1; f_addr = 32'h8; #1;
        checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b exp 1", f_gnt); end
        @(posedge clk); #1; reset_n = 1'b0; f_req = 1'b0; #1;
        checks++; if (f_rvalid !== 1'b0 || f_rdata !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL rmid_clear got v=%b %h err=%b exp 0", f_rvalid, f_rdata, err); end
        checks++; if (rom_ce !== 1'b0 || rom_pc !== 32'd0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rmid_rom got ce=%b pc=%h st=%0d exp 0", rom_ce, rom_pc, dbg_state); end
        @(negedge clk); reset_n = 1'b1; #1;
        checks++; if (f_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL rmid_idle got f=%b d=%b exp 0", f_gnt, d_gnt); end
        @(negedge clk); #1;
        checks++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0 || f_rdata !== 32'd0) begin errors++; $display("FAIL rmid_norv got f=%b d=%b %h exp 0", f_rvalid, d_rvalid, f_rdata); end
    endtask

    initial begin
        reset_n = 1'b0; f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;
        test_reset();
        test_fetch_seq();
        test_debug_alone();
        test_starvation();
        test_back_to_back();
        test_misaligned();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
